gf2_poly_div_31by16: RTL and testbench

//  Sequential GF(2) polynomial divider; the inverse of the 16-bit Karatsuba GF(2) multiplier.

---
 rtl/gf2_poly_div_31by16.sv | 134 +++++++++++++
 tb/tb_gf2_poly_div_31by16.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gf2_poly_div_31by16.sv
`default_nettype none
// ============================================================================
// Module      : gf2_poly_div_31by16
// Description : Bit-serial GF(2) polynomial long divider. Divides a DW-bit
//               dividend by a VW-bit divisor of any degree, one dividend bit
//               per cycle (MSB first). Returns quotient, remainder and a
//               divide-by-zero flag over valid/ready handshakes.
// Revision    : 1.0  initial release
// ============================================================================
module gf2_poly_div_31by16 #(
  parameter int DW = 31,
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-2:0] remainder,
  output logic          div_by_zero
);

  localparam int CW  = $clog2(DW);
  localparam int DGW = $clog2(VW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [DW-1:0]   a_reg;
  // The divisor's top bit is only ever cancelled against a running remainder
  // bit that is already known to be 1, so only the low VW-1 bits are kept.
  logic [VW-2:0]   b_reg;
  logic [DGW-1:0]  deg;
  // deg(R) < deg(B) <= VW-1 always holds, so R never needs more than VW-1 bits.
  logic [VW-2:0]   r_reg;
  logic [DW-1:0]   q_reg;
  logic [CW-1:0]   cnt;

  logic [DGW-1:0]  deg_in;
  logic [VW-1:0]   rn;
  logic            qb;
  logic [VW-2:0]   r_next;

  // Priority encoder: index of the highest set divisor bit.
  always_comb begin
    deg_in = '0;
    for (int i = 0; i < VW; i++) begin
      if (divisor[i]) deg_in = DGW'(i);
    end
  end

  // One long-division step: bring down the next dividend bit, subtract (XOR)
  // the divisor when the leading term of the partial remainder is set.
  always_comb begin
    rn     = {r_reg, a_reg[cnt]};
    qb     = rn[deg];
    r_next = qb ? (rn[VW-2:0] ^ b_reg) : rn[VW-2:0];
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      deg         <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= dividend;
            b_reg    <= divisor[VW-2:0];
            deg      <= deg_in;
            r_reg    <= '0;
            q_reg    <= '0;
            cnt      <= CW'(DW - 1);
            in_ready <= 1'b0;
            if (divisor == '0) begin
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              state       <= BUSY;
            end
          end
        end
        BUSY: begin
          r_reg <= r_next;
          q_reg <= {q_reg[DW-2:0], qb};
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          // First DONE cycle publishes the result; it then holds until taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
            quotient  <= q_reg;
            remainder <= r_reg;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gf2_poly_div_31by16.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf2_poly_div_31by16
// Description : Scoreboard bench for gf2_poly_div_31by16. Directed vectors
//               push expected results into a queue; a monitor compares them
//               when the divider presents a result.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gf2_poly_div_31by16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] quotient;
  logic [14:0] remainder;
  logic        div_by_zero;

  gf2_poly_div_31by16 #(.DW(31), .VW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] q;
    logic [14:0] r;
    logic        dbz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: latency and data on the first valid cycle, pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got out_valid=1 expected no result pending");
        end else begin
          chk("latency",     32'(cyc - sb[0].acc), 32'(sb[0].lat));
          chk("quotient",    {1'b0, quotient},     {1'b0, sb[0].q});
          chk("remainder",   {17'b0, remainder},   {17'b0, sb[0].r});
          chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, sb[0].dbz});
        end
      end
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
    end
    prev_ov = out_valid;
  end

  // Issue one operation; optionally record its expected result.
  task automatic send(input logic [30:0] a, input logic [15:0] b,
                      input logic [30:0] eq, input logic [14:0] er,
                      input logic edbz, input bit push);
    int n = 0;
    exp_t e;
    @(posedge clk); #1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    end else begin
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      if (push) begin
        e.q = eq; e.r = er; e.dbz = edbz;
        e.acc = cyc + 1;
        e.lat = (b == 16'd0) ? 1 : 32;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0 || out_valid)
      chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [30:0] clmul(input logic [15:0] a, input logic [15:0] b);
    logic [30:0] p = '0;
    for (int i = 0; i < 16; i++)
      if (b[i]) p = p ^ (31'(a) << i);
    return p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a16, b16;
    logic [14:0] rr, mask;
    int d;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready",  {31'b0, in_ready},    32'd1);
    chk("rst_out_valid", {31'b0, out_valid},   32'd0);
    chk("rst_quotient",  {1'b0, quotient},     32'd0);
    chk("rst_remainder", {17'b0, remainder},   32'd0);
    chk("rst_dbz",       {31'b0, div_by_zero}, 32'd0);

    // Hand-computed vectors
    send(31'h00000005, 16'h0003, 31'h00000003, 15'h0000, 1'b0, 1);
    send(31'h00000007, 16'h0003, 31'h00000002, 15'h0001, 1'b0, 1);
    send(31'h7FFFFFFF, 16'h8000, 31'h0000FFFF, 15'h7FFF, 1'b0, 1);
    send(31'h7FFFFFFF, 16'h0001, 31'h7FFFFFFF, 15'h0000, 1'b0, 1);
    send(31'h00000010, 16'h0007, 31'h00000006, 15'h0002, 1'b0, 1);
    send(31'h00000005, 16'h0010, 31'h00000000, 15'h0005, 1'b0, 1);
    send(31'h00000000, 16'h1234, 31'h00000000, 15'h0000, 1'b0, 1);
    send(31'h0000DEAD, 16'h0000, 31'h00000000, 15'h0000, 1'b1, 1);
    send(31'h00000006, 16'h0003, 31'h00000002, 15'h0000, 1'b0, 1);
    drain();

    // Backpressure: result held for 10 cycles, new requests ignored
    out_ready = 1'b0;
    send(31'h00000007, 16'h0003, 31'h00000002, 15'h0001, 1'b0, 1);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      in_valid = k[0];
      dividend = 31'h12345678;
      divisor  = 16'h0005;
      @(negedge clk);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready",  {31'b0, in_ready},  32'd0);
      chk("bp_quotient",  {1'b0, quotient},   32'd2);
      chk("bp_remainder", {17'b0, remainder}, 32'd1);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Round trip: y = a*b ^ r with deg r < deg b must give q = a, remainder r
    for (int k = 0; k < 25; k++) begin
      a16 = (k == 0) ? 16'hFFFF : 16'($urandom);
      b16 = (k == 0) ? 16'hFFFF : 16'($urandom);
      if (b16 == 16'd0) b16 = 16'd1;
      d = 0;
      for (int i = 0; i < 16; i++) if (b16[i]) d = i;
      mask = 15'((32'd1 << d) - 32'd1);
      rr = (k < 12) ? 15'd0 : (15'($urandom) & mask);
      send(clmul(a16, b16) ^ 31'(rr), b16, 31'(a16), rr, 1'b0, 1);
    end
    drain();

    // Reset mid-operation: aborted op yields no result
    send(31'h0ABCDEF1, 16'h0003, 31'h0, 15'h0, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready",  {31'b0, in_ready},  32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_quotient",  {1'b0, quotient},   32'd0);
    repeat (40) @(posedge clk);
    send(31'h00000010, 16'h0007, 31'h00000006, 15'h0002, 1'b0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
